// File: rtl/vc_envelope_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vc_envelope_sequencer_if
// Brief    : Control/phase bundle between keypad logic, sequencer and gain block
// Revision : 1.0
// ============================================================================
interface vc_envelope_sequencer_if #(
  parameter int CNT_W = 16
) ();

  logic             sample_tick;
  logic             start;
  logic             stop;
  logic             loop;
  logic [7:0]       attack_len;
  logic [CNT_W-1:0] hold_len;
  logic [7:0]       decay_len;
  logic [CNT_W-1:0] mute_len;

  logic             t1;
  logic             t2;
  logic             t3;
  logic             t4;
  logic             gain_enable;
  logic             busy;
  logic             done;
  logic [7:0]       burst_cnt;

  modport master (
    output sample_tick, start, stop, loop,
    output attack_len, hold_len, decay_len, mute_len,
    input  t1, t2, t3, t4, gain_enable, busy, done, burst_cnt
  );

  modport slave (
    input  sample_tick, start, stop, loop,
    input  attack_len, hold_len, decay_len, mute_len,
    output t1, t2, t3, t4, gain_enable, busy, done, burst_cnt
  );

endinterface
`default_nettype wire

// File: rtl/vc_envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vc_envelope_sequencer
// Brief    : Attack/hold/decay/mute phase controller for the gain-envelope block
// Revision : 1.0
// ============================================================================
module vc_envelope_sequencer #(
  parameter int CNT_W     = 16,
  parameter int DECAY_MAX = 131
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vc_envelope_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ATTACK = 3'd1,
    HOLD   = 3'd2,
    DECAY  = 3'd3,
    MUTE   = 3'd4
  } state_e;

  localparam logic [7:0]       DECAY_MAX_C = 8'(DECAY_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       atk_q, atk_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [7:0]       dec_q, dec_d;
  logic [CNT_W-1:0] mute_q, mute_d;
  logic [7:0]       burst_q, burst_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [3:0]       t_q, t_d;

  logic [7:0]       dec_clamp;
  logic [CNT_W-1:0] phase_len;
  logic             phase_end;
  logic             latch;
  logic [7:0]       burst_inc;
  state_e           first_new;
  state_e           next_cur;

  // Returns the next phase with a non-zero length after 'from'; IDLE as the
  // source means "start of burst", IDLE as the result means "burst complete".
  function automatic state_e next_phase(input state_e from,
                                        input logic   a_nz,
                                        input logic   h_nz,
                                        input logic   d_nz,
                                        input logic   m_nz);
    state_e nxt;
    nxt = IDLE;
    case (from)
      IDLE: begin
        if (a_nz)      nxt = ATTACK;
        else if (h_nz) nxt = HOLD;
        else if (d_nz) nxt = DECAY;
        else if (m_nz) nxt = MUTE;
      end
      ATTACK: begin
        if (h_nz)      nxt = HOLD;
        else if (d_nz) nxt = DECAY;
        else if (m_nz) nxt = MUTE;
      end
      HOLD: begin
        if (d_nz)      nxt = DECAY;
        else if (m_nz) nxt = MUTE;
      end
      DECAY: begin
        if (m_nz)      nxt = MUTE;
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  assign dec_clamp = (bus.decay_len > DECAY_MAX_C) ? DECAY_MAX_C : bus.decay_len;
  assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

  always_comb begin
    phase_len = '0;
    case (state_q)
      ATTACK:  phase_len = CNT_W'(atk_q);
      HOLD:    phase_len = hold_q;
      DECAY:   phase_len = CNT_W'(dec_q);
      MUTE:    phase_len = mute_q;
      default: phase_len = '0;
    endcase
  end

  assign phase_end = bus.sample_tick && (cnt_q == phase_len - CNT_ONE);
  assign first_new = next_phase(IDLE, bus.attack_len != 8'd0, bus.hold_len != '0,
                                dec_clamp != 8'd0, bus.mute_len != '0);
  assign next_cur  = next_phase(state_q, atk_q != 8'd0, hold_q != '0,
                                dec_q != 8'd0, mute_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    atk_d   = atk_q;
    hold_d  = hold_q;
    dec_d   = dec_q;
    mute_d  = mute_q;
    burst_d = burst_q;
    done_d  = 1'b0;
    latch   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          latch = 1'b1;
          cnt_d = '0;
          if (first_new == IDLE) begin
            done_d  = 1'b1;
            burst_d = burst_inc;
          end else begin
            state_d = first_new;
          end
        end
      end
      default: begin
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (phase_end) begin
          cnt_d = '0;
          if (next_cur != IDLE) begin
            state_d = next_cur;
          end else begin
            burst_d = burst_inc;
            if (bus.loop) begin
              latch   = 1'b1;
              state_d = first_new;
            end else begin
              state_d = IDLE;
            end
            // A loop whose fresh lengths are all zero has nothing to run.
            done_d = (state_d == IDLE);
          end
        end else if (bus.sample_tick) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase

    if (latch) begin
      atk_d  = bus.attack_len;
      hold_d = bus.hold_len;
      dec_d  = dec_clamp;
      mute_d = bus.mute_len;
    end

    case (state_d)
      ATTACK:  t_d = 4'b0001;
      HOLD:    t_d = 4'b0010;
      DECAY:   t_d = 4'b0100;
      default: t_d = 4'b1000;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      atk_q   <= '0;
      hold_q  <= '0;
      dec_q   <= '0;
      mute_q  <= '0;
      burst_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      t_q     <= 4'b1000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      atk_q   <= atk_d;
      hold_q  <= hold_d;
      dec_q   <= dec_d;
      mute_q  <= mute_d;
      burst_q <= burst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      t_q     <= t_d;
    end
  end

  // Phase selects are decoded from the next state so they switch on the same
  // edge as the state register and line up with the pass-through enable.
  assign bus.t1          = t_q[0];
  assign bus.t2          = t_q[1];
  assign bus.t3          = t_q[2];
  assign bus.t4          = t_q[3];
  assign bus.gain_enable = bus.sample_tick;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.burst_cnt   = burst_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_envelope_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vc_envelope_sequencer
// Brief    : Directed bench for the envelope phase sequencer
// Revision : 1.0
// ============================================================================
module tb_vc_envelope_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vc_envelope_sequencer_if #(.CNT_W(16)) bus ();

  vc_envelope_sequencer #(
    .CNT_W     (16),
    .DECAY_MAX (131)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int period, tick_ctr;
  int n_t1, n_t2, n_t3, n_t4, done_cnt, busy_at_done, onehot_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats(input int p);
    period = p; tick_ctr = 0;
    n_t1 = 0; n_t2 = 0; n_t3 = 0; n_t4 = 0;
    done_cnt = 0; busy_at_done = 0;
  endtask

  task automatic set_len(input int a, input int h, input int d, input int m);
    bus.attack_len = 8'(a);
    bus.hold_len   = 16'(h);
    bus.decay_len  = 8'(d);
    bus.mute_len   = 16'(m);
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next rise.
  // Ticks are credited to whichever phase select is high while the tick is driven.
  task automatic cyc();
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    if (bus.done) begin
      done_cnt++;
      if (bus.busy) busy_at_done++;
    end
    if ($countones({bus.t1, bus.t2, bus.t3, bus.t4}) != 1) onehot_err++;
    tick_ctr++;
    bus.sample_tick = (tick_ctr % period == 0);
    if (bus.sample_tick && bus.busy) begin
      if (bus.t1) n_t1++;
      if (bus.t2) n_t2++;
      if (bus.t3) n_t3++;
      if (bus.t4) n_t4++;
    end
  endtask

  task automatic do_start();
    cyc();
    bus.start = 1'b1;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < lim) begin
      cyc();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bus.sample_tick = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.loop        = 1'b0;
    set_len(0, 0, 0, 0);
    clear_stats(4);
    onehot_err = 0;

    rst_n = 1'b0;
    #12;
    check("rst_t4", 32'(bus.t4), 32'd1);
    check("rst_t123", 32'({bus.t1, bus.t2, bus.t3}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_burst", 32'(bus.burst_cnt), 32'd0);
    bus.sample_tick = 1'b1; #1;
    check("gen_follow_hi", 32'(bus.gain_enable), 32'd1);
    bus.sample_tick = 1'b0; #1;
    check("gen_follow_lo", 32'(bus.gain_enable), 32'd0);
    do_reset();

    // Full envelope 3/2/4/1, tick every 4 clocks
    clear_stats(4);
    set_len(3, 2, 4, 1);
    do_start();
    wait_done(300, "basic");
    check("basic_t1", 32'(n_t1), 32'd3);
    check("basic_t2", 32'(n_t2), 32'd2);
    check("basic_t3", 32'(n_t3), 32'd4);
    check("basic_t4", 32'(n_t4), 32'd1);
    check("basic_busy_at_done", 32'(busy_at_done), 32'd0);
    check("basic_burst", 32'(bus.burst_cnt), 32'd1);
    repeat (20) cyc();
    check("basic_single_done", 32'(done_cnt), 32'd1);

    // Hold-only envelope
    clear_stats(4);
    set_len(0, 5, 0, 0);
    do_start();
    cyc();
    check("hold_only_t2_next", 32'(bus.t2), 32'd1);
    wait_done(200, "hold_only");
    check("hold_only_t2", 32'(n_t2), 32'd5);
    check("hold_only_t1t3", 32'(n_t1 + n_t3), 32'd0);
    check("hold_only_burst", 32'(bus.burst_cnt), 32'd2);

    // Decay clamp
    clear_stats(2);
    set_len(0, 0, 200, 0);
    do_start();
    wait_done(600, "clamp");
    check("clamp_t3", 32'(n_t3), 32'd131);
    check("clamp_burst", 32'(bus.burst_cnt), 32'd3);

    // Looping bursts 1/1/1/1
    do_reset();
    clear_stats(2);
    set_len(1, 1, 1, 1);
    bus.loop = 1'b1;
    do_start();
    n = 0;
    while (bus.burst_cnt != 8'd3 && n < 200) begin
      cyc();
      n++;
    end
    check("loop_burst3", 32'(bus.burst_cnt), 32'd3);
    check("loop_no_done", 32'(done_cnt), 32'd0);
    check("loop_t1", 32'(n_t1), 32'd3);
    check("loop_t4", 32'(n_t4), 32'd3);
    n = 0;
    while (!(bus.t4 && bus.busy) && n < 50) begin
      cyc();
      n++;
    end
    check("loop_mute_seen", 32'(bus.t4 && bus.busy), 32'd1);
    bus.loop = 1'b0;
    wait_done(50, "loop_end");
    check("loop_end_burst", 32'(bus.burst_cnt), 32'd4);
    check("loop_end_done_once", 32'(done_cnt), 32'd1);

    // Stop on the second of five hold ticks
    clear_stats(4);
    set_len(1, 5, 2, 1);
    do_start();
    n = 0;
    while (!(n_t2 == 2 && bus.sample_tick && bus.t2) && n < 200) begin
      cyc();
      n++;
    end
    check("stop_hold_reached", 32'(n_t2), 32'd2);
    bus.stop = 1'b1;
    cyc();
    check("stop_hold_t4", 32'(bus.t4), 32'd1);
    check("stop_hold_busy", 32'(bus.busy), 32'd0);
    repeat (30) cyc();
    check("stop_hold_no_done", 32'(done_cnt), 32'd0);
    check("stop_hold_burst", 32'(bus.burst_cnt), 32'd4);
    check("stop_hold_no_t3", 32'(n_t3), 32'd0);

    // Stop coincident with the final attack tick
    clear_stats(4);
    set_len(2, 3, 0, 0);
    do_start();
    n = 0;
    while (!(n_t1 == 2 && bus.sample_tick && bus.t1) && n < 200) begin
      cyc();
      n++;
    end
    check("stop_atk_reached", 32'(n_t1), 32'd2);
    bus.stop = 1'b1;
    cyc();
    check("stop_atk_not_hold", 32'(bus.t2), 32'd0);
    check("stop_atk_t4", 32'(bus.t4), 32'd1);
    check("stop_atk_busy", 32'(bus.busy), 32'd0);
    repeat (20) cyc();
    check("stop_atk_no_t2", 32'(n_t2), 32'd0);
    check("stop_atk_no_done", 32'(done_cnt), 32'd0);

    // Stop and start together while idle: start ignored
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    check("start_stop_idle", 32'(bus.busy), 32'd0);

    // All-zero lengths
    clear_stats(4);
    set_len(0, 0, 0, 0);
    do_start();
    cyc();
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    cyc();
    check("zero_done_pulse", 32'(bus.done), 32'd0);
    check("zero_burst", 32'(bus.burst_cnt), 32'd5);

    // Start during decay is ignored, lengths not re-latched
    clear_stats(4);
    set_len(1, 1, 3, 1);
    do_start();
    n = 0;
    while (!bus.t3 && n < 100) begin
      cyc();
      n++;
    end
    check("busy_start_in_decay", 32'(bus.t3), 32'd1);
    set_len(9, 9, 9, 9);
    bus.start = 1'b1;
    wait_done(200, "busy_start");
    check("busy_start_t1", 32'(n_t1), 32'd1);
    check("busy_start_t3", 32'(n_t3), 32'd3);
    check("busy_start_t4", 32'(n_t4), 32'd1);
    check("busy_start_burst", 32'(bus.burst_cnt), 32'd6);

    // Asynchronous reset mid-attack
    clear_stats(4);
    set_len(10, 0, 0, 0);
    do_start();
    repeat (5) cyc();
    check("mid_atk_t1", 32'(bus.t1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_t4", 32'(bus.t4), 32'd1);
    check("arst_t1", 32'(bus.t1), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_burst", 32'(bus.burst_cnt), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("onehot", 32'(onehot_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
